// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the pipeline hazard controller.
//   hazardState_e : sequencer state (IDLE, MC_BUSY)
//   REG_ADDR_W    : architectural register address width
//   PERF_CNT_W    : width of the optional performance counters
//   satInc        : saturating increment used by the performance counters
// ---------------------------------------------------------------------------
package hazard_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int PERF_CNT_W = 16;

    typedef enum logic {
        IDLE    = 1'b0,
        MC_BUSY = 1'b1
    } hazardState_e;

    // Counters stick at all-ones rather than wrapping back to zero.
    function automatic logic [PERF_CNT_W-1:0] satInc(input logic [PERF_CNT_W-1:0] value);
        return (value == {PERF_CNT_W{1'b1}}) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/mc_stall_counter.sv
// ---------------------------------------------------------------------------
// mc_stall_counter
// Down-counter that tracks the remaining hold cycles of a multi-cycle EX op.
// Ports:
//   clk       in           core clock
//   reset_n   in           synchronous active-low reset (clears the count)
//   load      in           load loadValue (takes priority over dec)
//   loadValue in  [CNT_W]  value loaded on load
//   dec       in           decrement by one
//   zero      out          count is zero
// ---------------------------------------------------------------------------
module mc_stall_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] loadValue,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // Load wins over decrement so a fresh op always starts from a full count.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= loadValue;
        end else if (dec) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/hazard_controller.sv
// ---------------------------------------------------------------------------
// hazard_controller
// Hazard sequencer for the 5-stage core: resolves load-use stalls (one
// bubble), taken-branch flushes of IF/ID and ID/EX, and holds the front of
// the pipeline while a multi-cycle EX op completes.
// Parameters:
//   MC_LATENCY  total EX-occupancy cycles of a multi-cycle op (>=1)
//   CNT_W       width of the multi-cycle counter (must hold MC_LATENCY-1)
// Ports:
//   clk, reset_n              clock, synchronous active-low reset
//   idRs1, idRs2              source registers of the instruction in ID
//   exRd, exMemRead           destination / load flag of the instruction in EX
//   mcStart                   EX instruction is multi-cycle
//   branchTaken               EX resolved a taken branch/jump
//   pcWrite, ifidWrite        PC and IF/ID write enables
//   ifidFlush                 zero IF/ID
//   idexWrite, idexFlush      ID/EX write enable, NOP bubble into ID/EX
//   exmemBubble               bubble into EX/MEM while EX is held
//   busy                      sequencer is in MC_BUSY
// Optional build macro HAZARD_PERF_EN adds saturating 16-bit counters
//   luCnt, mcCnt, flushCnt    load-use stall, MC stall and flush cycles
// ---------------------------------------------------------------------------
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int MC_LATENCY = 4,
    parameter int CNT_W      = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [REG_ADDR_W-1:0] idRs1,
    input  logic [REG_ADDR_W-1:0] idRs2,
    input  logic [REG_ADDR_W-1:0] exRd,
    input  logic                  exMemRead,
    input  logic                  mcStart,
    input  logic                  branchTaken,
`ifdef HAZARD_PERF_EN
    output logic [PERF_CNT_W-1:0] luCnt,
    output logic [PERF_CNT_W-1:0] mcCnt,
    output logic [PERF_CNT_W-1:0] flushCnt,
`endif
    output logic                  pcWrite,
    output logic                  ifidWrite,
    output logic                  ifidFlush,
    output logic                  idexWrite,
    output logic                  idexFlush,
    output logic                  exmemBubble,
    output logic                  busy
);

    // A single-cycle "multi-cycle" op needs no hold at all.
    localparam bit              MC_NEEDS_HOLD = (MC_LATENCY > 1);
    localparam int              MC_LOAD_INT   = MC_NEEDS_HOLD ? (MC_LATENCY - 2) : 0;
    localparam logic [CNT_W-1:0] MC_LOAD      = MC_LOAD_INT[CNT_W-1:0];

    hazardState_e state;
    hazardState_e nextState;
    logic         loadUse;
    logic         cntLoad;
    logic         cntDec;
    logic         cntZero;

    assign loadUse = exMemRead && (exRd != '0) && ((exRd == idRs1) || (exRd == idRs2));

    mc_stall_counter #(
        .CNT_W(CNT_W)
    ) uMcStallCounter (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (cntLoad),
        .loadValue(MC_LOAD),
        .dec      (cntDec),
        .zero     (cntZero)
    );

    // Mealy output decode: hazards are answered in the same cycle they appear.
    // Reset forces the defaults regardless of the (possibly stale) state.
    always_comb begin
        pcWrite     = 1'b1;
        ifidWrite   = 1'b1;
        idexWrite   = 1'b1;
        ifidFlush   = 1'b0;
        idexFlush   = 1'b0;
        exmemBubble = 1'b0;
        busy        = 1'b0;
        nextState   = state;
        cntLoad     = 1'b0;
        cntDec      = 1'b0;
        if (reset_n) begin
            case (state)
                IDLE: begin
                    if (branchTaken) begin
                        ifidFlush = 1'b1;
                        idexFlush = 1'b1;
                    end else if (mcStart && MC_NEEDS_HOLD) begin
                        pcWrite     = 1'b0;
                        ifidWrite   = 1'b0;
                        idexWrite   = 1'b0;
                        exmemBubble = 1'b1;
                        cntLoad     = 1'b1;
                        nextState   = MC_BUSY;
                    end else if (loadUse) begin
                        pcWrite   = 1'b0;
                        ifidWrite = 1'b0;
                        idexFlush = 1'b1;
                    end
                end
                MC_BUSY: begin
                    busy = 1'b1;
                    if (!cntZero) begin
                        pcWrite     = 1'b0;
                        ifidWrite   = 1'b0;
                        idexWrite   = 1'b0;
                        exmemBubble = 1'b1;
                        cntDec      = 1'b1;
                    end else begin
                        nextState = IDLE;
                    end
                end
                default: nextState = IDLE;
            endcase
        end
    end

    // State register; a reset mid-op drops straight to IDLE with no release cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

`ifdef HAZARD_PERF_EN
    // Event counters derived from the decoded outputs: a load-use stall is the
    // only case that flushes ID/EX without also flushing IF/ID.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            luCnt    <= '0;
            mcCnt    <= '0;
            flushCnt <= '0;
        end else begin
            if (idexFlush && !ifidFlush) luCnt <= satInc(luCnt);
            if (exmemBubble)             mcCnt <= satInc(mcCnt);
            if (ifidFlush)               flushCnt <= satInc(flushCnt);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_controller.sv
module tb_hazard_controller;
    import hazard_pkg::*;

    // Output vector order: {pcWrite, ifidWrite, ifidFlush, idexWrite, idexFlush, exmemBubble, busy}
    localparam logic [6:0] EXP_DEF     = 7'b1101000;
    localparam logic [6:0] EXP_LU      = 7'b0001100;
    localparam logic [6:0] EXP_FLUSH   = 7'b1111100;
    localparam logic [6:0] EXP_MCSTART = 7'b0000010;
    localparam logic [6:0] EXP_MCHOLD  = 7'b0000011;
    localparam logic [6:0] EXP_RELEASE = 7'b1101001;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic [REG_ADDR_W-1:0] idRs1;
    logic [REG_ADDR_W-1:0] idRs2;
    logic [REG_ADDR_W-1:0] exRd;
    logic                  exMemRead;
    logic                  mcStart;
    logic                  branchTaken;
    logic                  pcWrite;
    logic                  ifidWrite;
    logic                  ifidFlush;
    logic                  idexWrite;
    logic                  idexFlush;
    logic                  exmemBubble;
    logic                  busy;
`ifdef HAZARD_PERF_EN
    logic [PERF_CNT_W-1:0] luCnt;
    logic [PERF_CNT_W-1:0] mcCnt;
    logic [PERF_CNT_W-1:0] flushCnt;
`endif

    int         vectors    = 0;
    int         miscompares = 0;
    logic [6:0] expQ[$];
    string      tagQ[$];

    always #5 clk = ~clk;

    hazard_controller #(
        .MC_LATENCY(4),
        .CNT_W     (3)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .idRs1      (idRs1),
        .idRs2      (idRs2),
        .exRd       (exRd),
        .exMemRead  (exMemRead),
        .mcStart    (mcStart),
        .branchTaken(branchTaken),
`ifdef HAZARD_PERF_EN
        .luCnt      (luCnt),
        .mcCnt      (mcCnt),
        .flushCnt   (flushCnt),
`endif
        .pcWrite    (pcWrite),
        .ifidWrite  (ifidWrite),
        .ifidFlush  (ifidFlush),
        .idexWrite  (idexWrite),
        .idexFlush  (idexFlush),
        .exmemBubble(exmemBubble),
        .busy       (busy)
    );

    task automatic checkOutput();
        logic [6:0] observed;
        logic [6:0] expected;
        string      tag;
        observed = {pcWrite, ifidWrite, ifidFlush, idexWrite, idexFlush, exmemBubble, busy};
        expected = expQ.pop_front();
        tag      = tagQ.pop_front();
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs just after the falling edge, queue the
    // expected Mealy outputs, and check them well before the rising edge.
    task automatic applyStimulus(input logic rstN, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic memRead, input logic mc,
                                 input logic br, input logic [6:0] expected, input string tag);
        @(negedge clk);
        reset_n     = rstN;
        idRs1       = rs1;
        idRs2       = rs2;
        exRd        = rd;
        exMemRead   = memRead;
        mcStart     = mc;
        branchTaken = br;
        expQ.push_back(expected);
        tagQ.push_back(tag);
        #2;
        checkOutput();
    endtask

    task automatic checkCount(input logic [15:0] observed, input logic [15:0] expected, input string tag);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        reset_n = 1'b0; idRs1 = '0; idRs2 = '0; exRd = '0;
        exMemRead = 1'b0; mcStart = 1'b0; branchTaken = 1'b0;

        //             rstN rs1 rs2 rd  ld mc br  expected     tag
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, EXP_DEF, "resetIgnoresInputs");
        applyStimulus(1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, EXP_DEF, "resetIgnoresLoadUse");
        applyStimulus(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, EXP_DEF, "idleDefaults");

        // Load-use on rs2 then on rs1; x0 and unrelated loads never stall.
        applyStimulus(1'b1, 5'd3, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, EXP_LU,  "loadUseRs2");
        applyStimulus(1'b1, 5'd3, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, EXP_DEF, "afterBubble");
        applyStimulus(1'b1, 5'd7, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0, EXP_LU,  "loadUseRs1");
        applyStimulus(1'b1, 5'd0, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, EXP_DEF, "x0Load");
        applyStimulus(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0, EXP_DEF, "loadNoDependency");
        applyStimulus(1'b1, 5'd8, 5'd2, 5'd8, 1'b0, 1'b0, 1'b0, EXP_DEF, "nonLoadMatch");

        // Multi-cycle op of latency 4: three hold cycles, release on the fourth.
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, EXP_MCSTART, "mcCycle1");
        applyStimulus(1'b1, 5'd6, 5'd0, 5'd6, 1'b1, 1'b1, 1'b1, EXP_MCHOLD,  "mcCycle2IgnoresBranchLu");
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, EXP_MCHOLD,  "mcCycle3");
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, EXP_RELEASE, "mcCycle4Release");

        // Back-to-back op restarts from IDLE right after the release.
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, EXP_MCSTART, "mcB2bCycle1");
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, EXP_MCHOLD,  "mcB2bCycle2");
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, EXP_MCHOLD,  "mcB2bCycle3");
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, EXP_RELEASE, "mcB2bRelease");
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, EXP_DEF,     "afterMc");

        // Branch beats load-use and multi-cycle start; no MC_BUSY entry follows.
        applyStimulus(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, EXP_FLUSH, "branchOverLoadUse");
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, EXP_FLUSH, "branchOverMc");
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, EXP_DEF,   "noBusyAfterBranch");

        // Reset on the second MC_BUSY cycle: straight back to IDLE, no release.
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, EXP_MCSTART, "rstMcCycle1");
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, EXP_MCHOLD,  "rstMcCycle2");
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, EXP_DEF,     "rstDuringBusy");
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, EXP_DEF,     "idleAfterReset");

`ifdef HAZARD_PERF_EN
        // Fresh reset, three load-use stalls and one latency-4 op.
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, EXP_DEF,     "perfReset");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 5'd4, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, EXP_LU,  "perfLoadUse");
            applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, EXP_DEF, "perfGap");
        end
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, EXP_MCSTART, "perfMc1");
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, EXP_MCHOLD,  "perfMc2");
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, EXP_MCHOLD,  "perfMc3");
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, EXP_RELEASE, "perfMc4");
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, EXP_DEF,     "perfIdle");
        checkCount(luCnt,    16'd3, "luCnt");
        checkCount(mcCnt,    16'd3, "mcCnt");
        checkCount(flushCnt, 16'd0, "flushCntBefore");

        // Hammer the flush counter past its saturation point.
        for (int i = 0; i < 70000; i++) begin
            @(negedge clk);
            branchTaken = 1'b1;
        end
        @(negedge clk);
        branchTaken = 1'b0;
        #2;
        checkCount(flushCnt, 16'hFFFF, "flushCntSaturated");
        checkCount(luCnt,    16'd3,    "luCntUnchanged");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
